// File: rtl/trap_collector_pkg.sv
// Shared trap types, widths and ROB age helpers for the trap collector.
package trap_collector_pkg;

  localparam int unsigned NUM_PORTS_DEF = 3;
  localparam int unsigned ROB_SIZE_DEF  = 16;
  localparam int unsigned RW_DEF        = $clog2(ROB_SIZE_DEF);
  localparam int unsigned XLEN_DEF      = 64;
  localparam int unsigned CAUSE_W       = 6;

  typedef logic [RW_DEF-1:0] rob_idx_t;

  // Synchronous exception codes
  typedef enum logic [CAUSE_W-1:0] {
    EXC_INST_MISALIGNED  = 6'd0,
    EXC_FETCH_FAULT      = 6'd1,
    EXC_INST_ILLEGAL     = 6'd2,
    EXC_BREAKPOINT       = 6'd3,
    EXC_LOAD_MISALIGNED  = 6'd4,
    EXC_LOAD_FAULT       = 6'd5,
    EXC_STORE_MISALIGNED = 6'd6,
    EXC_STORE_FAULT      = 6'd7,
    EXC_ECALL_U          = 6'd8,
    EXC_ECALL_S          = 6'd9,
    EXC_ECALL_M          = 6'd11,
    EXC_INST_PAGE_FAULT  = 6'd12,
    EXC_LOAD_PAGE_FAULT  = 6'd13,
    EXC_STORE_PAGE_FAULT = 6'd15
  } exception_t;

  // Asynchronous interrupt codes
  typedef enum logic [XLEN_DEF-1:0] {
    IRQ_S_SOFT  = 64'd1,
    IRQ_M_SOFT  = 64'd3,
    IRQ_S_TIMER = 64'd5,
    IRQ_M_TIMER = 64'd7,
    IRQ_S_EXT   = 64'd9,
    IRQ_M_EXT   = 64'd11
  } interrupt_t;

  // One exception report as carried from a writeback/execute port
  typedef struct packed {
    rob_idx_t              robIdx;
    exception_t            cause;
    logic [XLEN_DEF-1:0]   tval;
  } trap_rpt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_TRAP = 2'd2
  } trap_state_t;

  // Distance from the ROB head; wraps naturally in RW bits
  function automatic rob_idx_t rob_age(input rob_idx_t x, input rob_idx_t head);
    return rob_idx_t'(x - head);
  endfunction

  // True when a is strictly older than b relative to head
  function automatic logic is_older(input rob_idx_t a, input rob_idx_t b, input rob_idx_t head);
    return rob_age(a, head) < rob_age(b, head);
  endfunction

endpackage

// File: rtl/trap_collector_oldest_sel.sv
// Combinational picker: oldest surviving report across all ports.
module trap_collector_oldest_sel
  import trap_collector_pkg::*;
#(
  parameter int unsigned NUM_PORTS = NUM_PORTS_DEF
) (
  input  logic [NUM_PORTS-1:0] rpt_vld,
  input  trap_rpt_t            rpt [NUM_PORTS],
  input  rob_idx_t             head,
  input  logic                 squash_vld,
  input  rob_idx_t             squash_robIdx,
  output logic                 win_vld_c,
  output trap_rpt_t            win_c
);

  rob_idx_t sq_age;
  rob_idx_t cur_age;
  rob_idx_t best_age;

  // Strict less-than keeps the lowest port on equal age; younger-than-squash reports are masked
  always_comb begin
    win_vld_c = 1'b0;
    win_c     = '0;
    best_age  = '0;
    cur_age   = '0;
    sq_age    = rob_age(squash_robIdx, head);
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cur_age = rob_age(rpt[i].robIdx, head);
      if (rpt_vld[i] && !(squash_vld && (cur_age > sq_age)) &&
          (!win_vld_c || (cur_age < best_age))) begin
        win_vld_c = 1'b1;
        win_c     = rpt[i];
        best_age  = cur_age;
      end
    end
  end

endmodule

// File: rtl/trap_collector.sv
// Holds the oldest outstanding exception and raises precise traps or interrupts at commit.
module trap_collector
  import trap_collector_pkg::*;
#(
  parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
  parameter int unsigned ROB_SIZE  = ROB_SIZE_DEF,
  parameter int unsigned XLEN      = XLEN_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        i_rpt_vld,
  input  logic [NUM_PORTS*$clog2(ROB_SIZE)-1:0] i_rpt_robIdx,
  input  logic [NUM_PORTS*CAUSE_W-1:0] i_rpt_cause,
  input  logic [NUM_PORTS*XLEN-1:0]   i_rpt_tval,
  input  logic [$clog2(ROB_SIZE)-1:0] i_rob_head,
  input  logic                        i_commit_vld,
  input  logic [$clog2(ROB_SIZE)-1:0] i_commit_robIdx,
  input  logic                        i_squash_vld,
  input  logic [$clog2(ROB_SIZE)-1:0] i_squash_robIdx,
  input  logic                        i_irq_vld,
  input  logic [XLEN-1:0]             i_irq_cause,
  output logic                        o_hold_vld,
  output logic [$clog2(ROB_SIZE)-1:0] o_hold_robIdx,
  output logic                        o_trap_vld,
  output logic                        o_trap_is_irq,
  output logic [XLEN-1:0]             o_trap_cause,
  output logic [XLEN-1:0]             o_trap_tval,
  output logic [$clog2(ROB_SIZE)-1:0] o_trap_robIdx,
  input  logic                        i_trap_ack
);

  localparam int unsigned RW = $clog2(ROB_SIZE);

  trap_state_t     state_q;
  logic            hold_vld_q;
  trap_rpt_t       held_q;
  logic            trap_vld_q;
  logic            trap_is_irq_q;
  logic [XLEN-1:0] trap_cause_q;
  logic [XLEN-1:0] trap_tval_q;
  rob_idx_t        trap_robIdx_q;

  trap_rpt_t       rpt_c [NUM_PORTS];
  logic            win_vld_c;
  trap_rpt_t       win_c;
  logic            held_keep_c;
  logic            commit_hit_c;

  // Unpack the flat report buses into per-port records
  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      rpt_c[i].robIdx = i_rpt_robIdx[i*RW +: RW];
      rpt_c[i].cause  = exception_t'(i_rpt_cause[i*CAUSE_W +: CAUSE_W]);
      rpt_c[i].tval   = i_rpt_tval[i*XLEN +: XLEN];
    end
  end

  trap_collector_oldest_sel #(
    .NUM_PORTS(NUM_PORTS)
  ) u_oldest_sel (
    .rpt_vld       (i_rpt_vld),
    .rpt           (rpt_c),
    .head          (i_rob_head),
    .squash_vld    (i_squash_vld),
    .squash_robIdx (i_squash_robIdx),
    .win_vld_c     (win_vld_c),
    .win_c         (win_c)
  );

  // Held entry survives unless a squash flushes it; commit match is against the held tag
  always_comb begin
    held_keep_c  = hold_vld_q &&
                   !(i_squash_vld &&
                     (rob_age(held_q.robIdx, i_rob_head) > rob_age(i_squash_robIdx, i_rob_head)));
    commit_hit_c = hold_vld_q && i_commit_vld && (i_commit_robIdx == held_q.robIdx);
  end

  // Collector FSM with registered hold/trap outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hold_vld_q    <= 1'b0;
      held_q        <= '0;
      trap_vld_q    <= 1'b0;
      trap_is_irq_q <= 1'b0;
      trap_cause_q  <= '0;
      trap_tval_q   <= '0;
      trap_robIdx_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HELD: begin
          if (commit_hit_c) begin
            state_q       <= ST_TRAP;
            hold_vld_q    <= 1'b0;
            held_q        <= '0;
            trap_vld_q    <= 1'b1;
            trap_is_irq_q <= 1'b0;
            trap_cause_q  <= XLEN'(held_q.cause);
            trap_tval_q   <= held_q.tval;
            trap_robIdx_q <= held_q.robIdx;
          end else if (i_irq_vld && i_commit_vld) begin
            // The flush for the interrupt kills any held exception
            state_q       <= ST_TRAP;
            hold_vld_q    <= 1'b0;
            held_q        <= '0;
            trap_vld_q    <= 1'b1;
            trap_is_irq_q <= 1'b1;
            trap_cause_q  <= i_irq_cause;
            trap_tval_q   <= '0;
            trap_robIdx_q <= i_commit_robIdx;
          end else if (win_vld_c &&
                       (!held_keep_c || is_older(win_c.robIdx, held_q.robIdx, i_rob_head))) begin
            state_q    <= ST_HELD;
            hold_vld_q <= 1'b1;
            held_q     <= win_c;
          end else if (!held_keep_c) begin
            state_q    <= ST_IDLE;
            hold_vld_q <= 1'b0;
            held_q     <= '0;
          end
        end
        ST_TRAP: begin
          if (i_trap_ack) begin
            state_q       <= ST_IDLE;
            trap_vld_q    <= 1'b0;
            trap_is_irq_q <= 1'b0;
            trap_cause_q  <= '0;
            trap_tval_q   <= '0;
            trap_robIdx_q <= '0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          hold_vld_q <= 1'b0;
          held_q     <= '0;
          trap_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_hold_vld    = hold_vld_q;
  assign o_hold_robIdx = held_q.robIdx;
  assign o_trap_vld    = trap_vld_q;
  assign o_trap_is_irq = trap_is_irq_q;
  assign o_trap_cause  = trap_cause_q;
  assign o_trap_tval   = trap_tval_q;
  assign o_trap_robIdx = trap_robIdx_q;

endmodule
